// File: rtl/riscv_dmem_store_buffer_if_pkg.sv
// Shared definitions for the data-memory store-buffer interface:
// FSM state encoding, word-offset constant and default widths.
package riscv_dmem_pkg;

  localparam int WORD_OFS     = 2;
  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_SB_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_WAIT  = 2'd1,
    DRAIN_WAIT = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/riscv_dmem_store_buffer_if_if.sv
// Word-access data port shared by the core side and the memory side.
// The requester drives re/we/fence/addr/wdata; the responder returns
// rdata and stall. The memory side never uses fence.
interface dmem_port_if
  import riscv_dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              re;
  logic              we;
  logic              fence;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              stall;

  modport master (
    output re, we, fence, addr, wdata,
    input  rdata, stall
  );

  modport slave (
    input  re, we, fence, addr, wdata,
    output rdata, stall
  );

endinterface

// File: rtl/riscv_dmem_store_buffer_if_sb.sv
// Circular store buffer of {word address, data} with a valid vector.
// Provides head-entry outputs for draining and a youngest-match lookup
// for load forwarding. SB_DEPTH must be a power of two and >= 2 so the
// pointers wrap naturally.
module dmem_store_buffer
  import riscv_dmem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SB_DEPTH = DEF_SB_DEPTH,
  localparam int PTR_W   = $clog2(SB_DEPTH),
  localparam int CNT_W   = PTR_W + 1,
  localparam int WA_W    = ADDR_W - WORD_OFS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enq,
  input  logic [WA_W-1:0]   enq_waddr,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              deq,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic [WA_W-1:0]   head_waddr,
  output logic [DATA_W-1:0] head_data,
  input  logic [WA_W-1:0]   lk_waddr,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data
);

  logic [WA_W-1:0]   waddr_q [SB_DEPTH];
  logic [DATA_W-1:0] data_q  [SB_DEPTH];
  logic [SB_DEPTH-1:0] valid_q;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  scan_idx;
  logic              do_enq;
  logic              do_deq;

  assign full       = (count_q == CNT_W'(SB_DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign head_waddr = waddr_q[head_q];
  assign head_data  = data_q[head_q];

  // A full buffer may still accept when the head leaves in the same cycle.
  assign do_enq = enq && (!full || deq);
  assign do_deq = deq && !empty;

  // Entry payload: written at the tail, no reset needed.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      waddr_q[tail_q] <= enq_waddr;
      data_q[tail_q]  <= enq_data;
    end
  end

  // Pointers, occupancy and valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (do_deq) begin
        head_q          <= head_q + PTR_W'(1);
        valid_q[head_q] <= 1'b0;
      end
      if (do_enq) begin
        tail_q          <= tail_q + PTR_W'(1);
        valid_q[tail_q] <= 1'b1;
      end
      case ({do_enq, do_deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    lk_hit   = 1'b0;
    lk_data  = '0;
    scan_idx = head_q;
    for (int i = 0; i < SB_DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (valid_q[scan_idx] && (waddr_q[scan_idx] == lk_waddr)) begin
        lk_hit  = 1'b1;
        lk_data = data_q[scan_idx];
      end
    end
  end

endmodule

// File: rtl/riscv_dmem_store_buffer_if.sv
// Data-memory interface between the single-cycle core and the cached
// data memory. Stores are posted into a store buffer, loads are forwarded
// from it when possible, and the buffer drains to memory in the
// background. Loads take priority over draining; at most one memory
// request is outstanding.
module riscv_dmem_store_buffer_if
  import riscv_dmem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SB_DEPTH = DEF_SB_DEPTH,
  localparam int CNT_W   = $clog2(SB_DEPTH) + 1,
  localparam int WA_W    = ADDR_W - WORD_OFS
) (
  input  logic          clk,
  input  logic          reset,
  dmem_port_if.slave    core,
  dmem_port_if.master   mem
);

  dmem_state_e       state_q;
  logic [ADDR_W-1:0] ld_addr_q;

  logic              sb_full;
  logic              sb_empty;
  logic [CNT_W-1:0]  sb_count;
  logic [WA_W-1:0]   sb_head_waddr;
  logic [DATA_W-1:0] sb_head_data;
  logic              sb_hit;
  logic [DATA_W-1:0] sb_hit_data;
  logic              sb_enq;
  logic              sb_deq;

  logic              in_idle;
  logic              ld_req;
  logic              ld_issue;
  logic              dr_issue;
  logic              rd_act;
  logic              wr_act;
  logic              ld_stall;
  logic              st_stall;
  logic              fn_stall;

  dmem_store_buffer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk        (clk),
    .rst_n      (reset),
    .enq        (sb_enq),
    .enq_waddr  (core.addr[ADDR_W-1:WORD_OFS]),
    .enq_data   (core.wdata),
    .deq        (sb_deq),
    .full       (sb_full),
    .empty      (sb_empty),
    .count      (sb_count),
    .head_waddr (sb_head_waddr),
    .head_data  (sb_head_data),
    .lk_waddr   (core.addr[ADDR_W-1:WORD_OFS]),
    .lk_hit     (sb_hit),
    .lk_data    (sb_hit_data)
  );

  // Request selection, stall generation and the forwarding mux.
  always_comb begin
    in_idle  = (state_q == IDLE);
    ld_req   = core.re && !sb_hit;
    ld_issue = in_idle && ld_req;
    dr_issue = in_idle && !ld_req && !sb_empty;
    rd_act   = ld_issue || (state_q == LOAD_WAIT);
    wr_act   = dr_issue || (state_q == DRAIN_WAIT);
    sb_deq   = wr_act && !mem.stall;

    // An unforwarded load waits out a drain, then waits on memory.
    ld_stall = ld_req && ((state_q == DRAIN_WAIT) || mem.stall);
    st_stall = core.we && sb_full && !sb_deq;
    fn_stall = core.fence && ((sb_count != '0) || !in_idle);
    sb_enq   = core.we && !st_stall;

    mem.fence  = 1'b0;
    mem.re     = 1'b0;
    mem.we     = 1'b0;
    mem.addr   = '0;
    mem.wdata  = '0;
    core.rdata = '0;
    core.stall = 1'b0;

    // Outputs are held quiet while reset is asserted.
    if (reset) begin
      if (rd_act) begin
        mem.re   = 1'b1;
        mem.addr = in_idle ? core.addr : ld_addr_q;
      end else if (wr_act) begin
        mem.we    = 1'b1;
        mem.addr  = {sb_head_waddr, {WORD_OFS{1'b0}}};
        mem.wdata = sb_head_data;
      end
      if (core.re) begin
        core.rdata = sb_hit ? sb_hit_data : mem.rdata;
      end
      core.stall = ld_stall || st_stall || fn_stall;
    end
  end

  // Load address captured at issue so the stalled request stays stable.
  always_ff @(posedge clk) begin
    if (ld_issue) begin
      ld_addr_q <= core.addr;
    end
  end

  // Outstanding-request FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_issue && mem.stall) begin
            state_q <= LOAD_WAIT;
          end else if (dr_issue && mem.stall) begin
            state_q <= DRAIN_WAIT;
          end
        end
        LOAD_WAIT: begin
          if (!mem.stall) begin
            state_q <= IDLE;
          end
        end
        DRAIN_WAIT: begin
          if (!mem.stall) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
